axis_byte_frame_tx: RTL and testbench
=====================================

# axis_byte_frame_tx

AXI-Stream byte transmitter: the sending end paired with the 8-bit AXI-Stream register/receiver. Bytes are pushed into an internal FIFO and emitted as fixed-length frames, one beat per accepted handshake. T_last_out marks the final beat of each frame, and a wrapping frame counter tracks completed frames. It sits between a byte producer and any downstream AXI-Stream slave.

## Interface
- DATA_W, 8, beat data width
- DEPTH, 32, FIFO entries (power of two)
- CNT_W, 5, width of frame_len and frame_cnt
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- wr_data  input  DATA_W  byte pushed into FIFO
- wr_en  input  1  push strobe
- wr_full  output  1  FIFO holds DEPTH entries
- wr_overflow  output  1  sticky; set by wr_en while wr_full
- frame_len  input  CNT_W  beats per frame, 1..31; 0 = transmitter held idle
- T_data_out  output  DATA_W  stream data
- T_valid_out  output  1  stream valid
- T_ready  input  1  downstream ready
- T_last_out  output  1  last beat of frame
- frame_cnt  output  CNT_W  completed frames, wraps 31->0

## Operation
- Handshake: beat transfers at posedge when T_valid_out && T_ready.
- Once asserted, T_valid_out, T_data_out and T_last_out hold stable until that beat transfers.
- FIFO push: wr_en && !wr_full stores wr_data.
- FIFO full: wr_en && wr_full drops the byte, leaves the FIFO unchanged, and sets wr_overflow.
- Simultaneous push and pop: occupancy unchanged.
- Start condition: frame_len != 0 and occupancy >= frame_len. A frame therefore never starves and T_valid_out never drops mid-frame.
- frame_len is latched at frame start. Changes mid-frame take effect at the next frame.
- FSM IDLE:
  - On start condition: pop the first byte into the output register, load beats_left = latched_len - 1, go to SEND.
  - T_last_out = (latched_len == 1).
- FSM SEND:
  - On a handshake with beats_left != 0: pop the next byte into the output register, decrement beats_left, assert T_last_out when beats_left becomes 0.
  - On a handshake of the last beat: frame_cnt += 1 (mod 2^CNT_W).
    - If the start condition holds in that same cycle (evaluated on post-pop occupancy), begin the next frame immediately with no bubble.
    - Otherwise deassert T_valid_out and go to IDLE.
- No handshake: all outputs hold.
- Reset, including mid-frame: T_valid_out drops immediately, the partial frame is discarded, the FIFO is emptied, and the FSM returns to IDLE.

## Timing
- Reset values:
  - T_valid_out=0, T_last_out=0, T_data_out=0
  - frame_cnt=0
  - wr_full=0, wr_overflow=0
  - FIFO empty, FSM IDLE
- Push at edge N: occupancy updated at N. The start condition can first be true in cycle N+1, which makes T_valid_out=1 after edge N+1. First beat latency from push to T_valid_out: 2 cycles.
- Throughput with T_ready held high and sufficient data: 1 beat/cycle, including across frame boundaries.
- frame_cnt increments on the edge that transfers the last beat.
- wr_full and wr_overflow are registered and reflect occupancy after the current edge.

## Structure
- Shared package axis_pkg:
  - DATA_W, CNT_W defaults
  - tx_state_t enum {IDLE, SEND}
- Sub-module axis_byte_fifo:
  - synchronous single-clock FIFO, DEPTH x DATA_W
  - ports: push, pop, data in/out, occupancy count (log2(DEPTH)+1 bits), full, empty
- The top level holds the FSM, output register, beats_left, frame_cnt and wr_overflow.

## Test plan
- Reset then idle: push 0x12, 0x22, 0x33 with frame_len=3, T_ready=1 -> beats 0x12, 0x22, 0x33 on consecutive cycles, T_last_out only with 0x33, frame_cnt=1.
- Backpressure: frame_len=2, push 0x44, 0x55, T_ready=0 for 5 cycles then 1 -> T_valid_out=1 with 0x44 held stable throughout the stall, then 0x44 and 0x55 transfer, frame_cnt increments once.
- Insufficient data: frame_len=4, push 3 bytes -> T_valid_out stays 0; push 4th byte 0x88 -> frame starts 2 cycles later, 0x88 carries T_last_out.
- Back-to-back frames: frame_len=2, push 0xAA, 0xBB, 0xCC, 0xDD, T_ready=1 -> 4 beats on 4 consecutive cycles, T_last_out on 0xBB and 0xDD, frame_cnt=2; 32 frames wrap frame_cnt to 0.
- Overflow: no T_ready, push 33 bytes -> wr_full=1 after the 32nd push, 33rd byte dropped, wr_overflow=1 until reset.
- Reset mid-frame: frame_len=4, assert reset after 2 beats -> T_valid_out=0 immediately, FIFO empty, frame_cnt=0; post-reset push of 4 new bytes produces a clean frame.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream byte frame transmitter.
package axis_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

endpackage

// File: rtl/axis_byte_fifo.sv
// Single-clock FIFO with combinational read of the head entry.
// Pushes to a full FIFO and pops from an empty one are ignored.
module axis_byte_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count_next;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) count_next = count + 1'b1;
        if (do_pop && !do_push) count_next = count - 1'b1;
    end

    // NOTE: storage is deliberately not reset; the pointers and count define
    // which entries are valid, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/axis_byte_frame_tx.sv
// Byte FIFO feeding an AXI-Stream master that emits fixed-length frames,
// starting a frame only once the whole frame is already buffered.
module axis_byte_frame_tx
    import axis_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 32,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    output logic              wr_full,
    output logic              wr_overflow,
    input  logic [CNT_W-1:0]  frame_len,
    output logic [DATA_W-1:0] T_data_out,
    output logic              T_valid_out,
    input  logic              T_ready,
    output logic              T_last_out,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int AW = $clog2(DEPTH);

    tx_state_t         state;
    logic [CNT_W-1:0]  beats_left;
    logic [AW:0]       count;
    logic [DATA_W-1:0] fifo_q;
    logic              fifo_empty;
    logic              pop;
    logic              handshake;
    logic              start_ok;

    axis_byte_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (wr_en),
        .pop    (pop),
        .din    (wr_data),
        .dout   (fifo_q),
        .count  (count),
        .full   (wr_full),
        .empty  (fifo_empty)
    );

    assign handshake = T_valid_out && T_ready;

    // A frame may start only when every one of its bytes is already buffered,
    // so valid never has to drop in the middle of a frame.
    assign start_ok = (frame_len != '0) && (32'(count) >= 32'(frame_len));

    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE: pop = start_ok;
            SEND: pop = handshake && ((beats_left != '0) || start_ok);
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            T_data_out  <= '0;
            T_valid_out <= 1'b0;
            T_last_out  <= 1'b0;
            beats_left  <= '0;
            frame_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        T_data_out  <= fifo_q;
                        T_valid_out <= 1'b1;
                        T_last_out  <= (frame_len == CNT_W'(1));
                        beats_left  <= frame_len - 1'b1;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        if (beats_left != '0) begin
                            T_data_out <= fifo_q;
                            T_last_out <= (beats_left == CNT_W'(1));
                            beats_left <= beats_left - 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                            // Chain straight into the next frame to avoid a bubble.
                            if (start_ok) begin
                                T_data_out <= fifo_q;
                                T_last_out <= (frame_len == CNT_W'(1));
                                beats_left <= frame_len - 1'b1;
                            end else begin
                                T_valid_out <= 1'b0;
                                T_last_out  <= 1'b0;
                                state       <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  wr_overflow <= 1'b0;
        else if (wr_en && wr_full)  wr_overflow <= 1'b1;
    end

endmodule

// File: tb/tb_axis_byte_frame_tx.sv
// Directed self-checking bench for axis_byte_frame_tx.
module tb_axis_byte_frame_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] wr_data = '0;
    logic       wr_en = 1'b0;
    logic       wr_full;
    logic       wr_overflow;
    logic [4:0] frame_len = '0;
    logic [7:0] T_data_out;
    logic       T_valid_out;
    logic       T_ready = 1'b0;
    logic       T_last_out;
    logic [4:0] frame_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int push_cyc = 0;

    logic [8:0] beat_q[$];
    int         beat_cyc[$];

    axis_byte_frame_tx dut (
        .clk         (clk),
        .reset       (reset),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .wr_full     (wr_full),
        .wr_overflow (wr_overflow),
        .frame_len   (frame_len),
        .T_data_out  (T_data_out),
        .T_valid_out (T_valid_out),
        .T_ready     (T_ready),
        .T_last_out  (T_last_out),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // A beat seen valid+ready here transfers on the following rising edge.
    always @(negedge clk) begin
        if (!reset && T_valid_out && T_ready) begin
            beat_q.push_back({T_last_out, T_data_out});
            beat_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_en = 1'b0;
        tick(2);
        beat_q.delete();
        beat_cyc.delete();
        reset = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        tick(1);
        wr_en    = 1'b0;
        push_cyc = cyc;
    endtask

    task automatic wait_beats(input int n, input int budget, input string name);
        for (int c = 0; c < budget && beat_q.size() < n; c++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (beat_q.size() < n) begin
            errors++;
            $display("FAIL %s timeout: beats=%0d required=%0d", name, beat_q.size(), n);
        end
    endtask

    task automatic check_beat(input int idx, input logic [7:0] d, input logic l, input string name);
        checks++;
        if (idx >= beat_q.size()) begin
            errors++;
            $display("FAIL %s beat %0d missing", name, idx);
        end else if (beat_q[idx] !== {l, d}) begin
            errors++;
            $display("FAIL %s beat %0d: got last=%0b data=%02h required last=%0b data=%02h",
                     name, idx, beat_q[idx][8], beat_q[idx][7:0], l, d);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(1);
        checks++;
        if ({T_valid_out, T_last_out, T_data_out, frame_cnt, wr_full, wr_overflow} !== '0) begin
            errors++;
            $display("FAIL reset_values: valid=%0b last=%0b data=%02h cnt=%0d full=%0b ovf=%0b required all 0",
                     T_valid_out, T_last_out, T_data_out, frame_cnt, wr_full, wr_overflow);
        end
        do_reset();
        frame_len = 5'd3;
        T_ready   = 1'b1;
        tick(4);
        checks++;
        if (T_valid_out !== 1'b0 || beat_q.size() != 0) begin
            errors++;
            $display("FAIL idle_empty: valid=%0b beats=%0d required 0 0", T_valid_out, beat_q.size());
        end
    endtask

    task automatic test_basic();
        do_reset();
        frame_len = 5'd3;
        T_ready   = 1'b1;
        push_byte(8'h12);
        push_byte(8'h22);
        push_byte(8'h33);
        wait_beats(3, 20, "basic");
        tick(3);
        check_beat(0, 8'h12, 1'b0, "basic");
        check_beat(1, 8'h22, 1'b0, "basic");
        check_beat(2, 8'h33, 1'b1, "basic");
        checks++;
        if (beat_q.size() == 3 && (beat_cyc[1] != beat_cyc[0] + 1 || beat_cyc[2] != beat_cyc[0] + 2)) begin
            errors++;
            $display("FAIL basic_consecutive: cycles %0d %0d %0d", beat_cyc[0], beat_cyc[1], beat_cyc[2]);
        end
        checks++;
        if (frame_cnt !== 5'd1) begin
            errors++;
            $display("FAIL basic_frame_cnt: got %0d required 1", frame_cnt);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        frame_len = 5'd2;
        T_ready   = 1'b0;
        push_byte(8'h44);
        push_byte(8'h55);
        tick(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (T_valid_out !== 1'b1 || T_data_out !== 8'h44 || T_last_out !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: valid=%0b data=%02h last=%0b required 1 44 0",
                         i, T_valid_out, T_data_out, T_last_out);
            end
        end
        tick(1);
        T_ready = 1'b1;
        wait_beats(2, 20, "backpressure");
        tick(3);
        check_beat(0, 8'h44, 1'b0, "backpressure");
        check_beat(1, 8'h55, 1'b1, "backpressure");
        checks++;
        if (frame_cnt !== 5'd1 || beat_q.size() != 2) begin
            errors++;
            $display("FAIL backpressure_end: cnt=%0d beats=%0d required 1 2", frame_cnt, beat_q.size());
        end
    endtask

    task automatic test_insufficient();
        do_reset();
        frame_len = 5'd4;
        T_ready   = 1'b1;
        push_byte(8'h55);
        push_byte(8'h66);
        push_byte(8'h77);
        tick(4);
        checks++;
        if (T_valid_out !== 1'b0 || beat_q.size() != 0) begin
            errors++;
            $display("FAIL short_data_idle: valid=%0b beats=%0d required 0 0", T_valid_out, beat_q.size());
        end
        push_byte(8'h88);
        wait_beats(4, 20, "insufficient");
        tick(3);
        checks++;
        if (beat_q.size() != 0 && beat_cyc[0] != push_cyc + 1) begin
            errors++;
            $display("FAIL first_beat_latency: first valid edge %0d required %0d", beat_cyc[0], push_cyc + 1);
        end
        check_beat(0, 8'h55, 1'b0, "insufficient");
        check_beat(3, 8'h88, 1'b1, "insufficient");
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        logic       exp_l [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        frame_len = 5'd2;
        T_ready   = 1'b1;
        for (int i = 0; i < 4; i++) push_byte(exp_d[i]);
        wait_beats(4, 20, "b2b");
        tick(3);
        for (int i = 0; i < 4; i++) check_beat(i, exp_d[i], exp_l[i], "b2b");
        checks++;
        if (beat_q.size() == 4 && beat_cyc[3] != beat_cyc[0] + 3) begin
            errors++;
            $display("FAIL b2b_no_bubble: span %0d cycles required 3", beat_cyc[3] - beat_cyc[0]);
        end
        checks++;
        if (frame_cnt !== 5'd2) begin
            errors++;
            $display("FAIL b2b_frame_cnt: got %0d required 2", frame_cnt);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        frame_len = 5'd1;
        T_ready   = 1'b1;
        for (int i = 0; i < 31; i++) push_byte(8'(i));
        wait_beats(31, 100, "wrap31");
        tick(3);
        checks++;
        if (frame_cnt !== 5'd31) begin
            errors++;
            $display("FAIL frame_cnt_31: got %0d required 31", frame_cnt);
        end
        push_byte(8'h5A);
        wait_beats(32, 20, "wrap32");
        tick(3);
        checks++;
        if (frame_cnt !== 5'd0) begin
            errors++;
            $display("FAIL frame_cnt_wrap: got %0d required 0", frame_cnt);
        end
        check_beat(31, 8'h5A, 1'b1, "wrap");
    endtask

    task automatic test_overflow();
        do_reset();
        frame_len = 5'd0;
        T_ready   = 1'b0;
        for (int i = 0; i < 31; i++) push_byte(8'(i));
        checks++;
        if (wr_full !== 1'b0) begin
            errors++;
            $display("FAIL full_at_31: got %0b required 0", wr_full);
        end
        push_byte(8'd31);
        checks++;
        if (wr_full !== 1'b1 || wr_overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_at_32: full=%0b ovf=%0b required 1 0", wr_full, wr_overflow);
        end
        push_byte(8'hEE);
        checks++;
        if (wr_overflow !== 1'b1 || wr_full !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: ovf=%0b full=%0b required 1 1", wr_overflow, wr_full);
        end
        frame_len = 5'd1;
        T_ready   = 1'b1;
        wait_beats(32, 100, "drain");
        tick(4);
        checks++;
        if (beat_q.size() != 32) begin
            errors++;
            $display("FAIL drain_count: got %0d required 32", beat_q.size());
        end
        check_beat(31, 8'd31, 1'b1, "drain");
        checks++;
        if (wr_overflow !== 1'b1 || wr_full !== 1'b0) begin
            errors++;
            $display("FAIL overflow_sticky: ovf=%0b full=%0b required 1 0", wr_overflow, wr_full);
        end
        do_reset();
        checks++;
        if (wr_overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_cleared: got %0b required 0", wr_overflow);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        frame_len = 5'd4;
        T_ready   = 1'b1;
        for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i));
        wait_beats(2, 20, "midframe");
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if (T_valid_out !== 1'b0 || frame_cnt !== 5'd0 || wr_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_midframe: valid=%0b cnt=%0d full=%0b required 0 0 0",
                     T_valid_out, frame_cnt, wr_full);
        end
        tick(1);
        beat_q.delete();
        beat_cyc.delete();
        // With one-beat frames, any byte left over from before reset would appear.
        frame_len = 5'd1;
        reset = 1'b0;
        tick(5);
        checks++;
        if (beat_q.size() != 0) begin
            errors++;
            $display("FAIL fifo_emptied: leftover beats=%0d required 0", beat_q.size());
        end
        frame_len = 5'd4;
        for (int i = 0; i < 4; i++) push_byte(8'hD0 + 8'(i));
        wait_beats(4, 20, "post_reset");
        tick(3);
        for (int i = 0; i < 4; i++) check_beat(i, 8'hD0 + 8'(i), (i == 3), "post_reset");
        checks++;
        if (frame_cnt !== 5'd1) begin
            errors++;
            $display("FAIL post_reset_cnt: got %0d required 1", frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_insufficient();
        test_back_to_back();
        test_wrap();
        test_overflow();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
